// File: rtl/div_pkg.sv
// Shared encodings and widths for the multi-cycle divider.
// DIV_SIGNED_EN (in div.sv) enables the signed path.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam int   DoubleRegBus      = 64;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if no borrow.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q
);

  logic [DATA_W:0] trial;
  logic [DATA_W:0] dvs;

  assign trial = {rem, bit_in};
  assign dvs   = {1'b0, divisor};
  assign q     = (trial >= dvs);
  // rem < divisor on entry, so a kept difference always fits
  assign rem_out = q ? DATA_W'(trial - dvs) : trial[DATA_W-1:0];

endmodule

// File: rtl/div.sv
// Multi-cycle restoring divider for the execute stage.
// Define DIV_SIGNED_EN to build the signed (abs/negate) path.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CW = $clog2(DATA_W + 1);

  div_state_e          state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [DATA_W-1:0]   dvd, dvd_n;
  logic [DATA_W-1:0]   dvs, dvs_n;
  logic [DATA_W-1:0]   rem, rem_n;
  logic [DATA_W-1:0]   quo, quo_n;
  logic                ready_n;
  logic [2*DATA_W-1:0] res_n;
  logic [DATA_W-1:0]   step_rem;
  logic                step_q;
  logic [DATA_W-1:0]   fix_q, fix_r;
  logic [DATA_W-1:0]   in_a, in_b;

`ifdef DIV_SIGNED_EN
  logic sa, sb, sa_n, sb_n;
  logic neg_a, neg_b;

  assign neg_a = signed_div_i & opdata1_i[DATA_W-1];
  assign neg_b = signed_div_i & opdata2_i[DATA_W-1];
  assign in_a  = neg_a ? -opdata1_i : opdata1_i;
  assign in_b  = neg_b ? -opdata2_i : opdata2_i;
  assign fix_q = (sa ^ sb) ? -quo : quo;
  assign fix_r = sa ? -rem : rem;
`else
  logic unused_signed;

  assign unused_signed = signed_div_i;
  assign in_a  = opdata1_i;
  assign in_b  = opdata2_i;
  assign fix_q = quo;
  assign fix_r = rem;
`endif

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem     (rem),
    .bit_in  (dvd[DATA_W-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q       (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      ready_o  <= DivResultNotReady;
      result_o <= '0;
`ifdef DIV_SIGNED_EN
      sa       <= 1'b0;
      sb       <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dvd      <= dvd_n;
      dvs      <= dvs_n;
      rem      <= rem_n;
      quo      <= quo_n;
      ready_o  <= ready_n;
      result_o <= res_n;
`ifdef DIV_SIGNED_EN
      sa       <= sa_n;
      sb       <= sb_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dvd_n   = dvd;
    dvs_n   = dvs;
    rem_n   = rem;
    quo_n   = quo;
    ready_n = ready_o;
    res_n   = result_o;
`ifdef DIV_SIGNED_EN
    sa_n    = sa;
    sb_n    = sb;
`endif
    unique case (state)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = DivByZero;
          end else begin
            state_n = DivOn;
            cnt_n   = '0;
            dvd_n   = in_a;
            dvs_n   = in_b;
            rem_n   = '0;
            quo_n   = '0;
`ifdef DIV_SIGNED_EN
            sa_n    = neg_a;
            sb_n    = neg_b;
`endif
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_n = DivFree;
          ready_n = DivResultNotReady;
          res_n   = '0;
        end else begin
          state_n = DivEnd;
          ready_n = DivResultReady;
          res_n   = '0;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_n = DivFree;
          ready_n = DivResultNotReady;
          res_n   = '0;
        end else if (cnt == CW'(DATA_W)) begin
          state_n = DivEnd;
          ready_n = DivResultReady;
          res_n   = {fix_r, fix_q};
        end else begin
          rem_n = step_rem;
          quo_n = {quo[DATA_W-2:0], step_q};
          dvd_n = {dvd[DATA_W-2:0], 1'b0};
          cnt_n = cnt + 1'b1;
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_n = DivFree;
          ready_n = DivResultNotReady;
          res_n   = '0;
        end
      end
      default: begin
        state_n = DivFree;
        ready_n = DivResultNotReady;
        res_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for div with an arithmetic reference model.
// Expectations follow DIV_SIGNED_EN when it is defined.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        sg;
  logic [31:0] opa, opb;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (sg),
    .opdata1_i    (opa),
    .opdata2_i    (opb),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    longint x, y, q, r;
    if (b == 0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
    end
`endif
    x = longint'({32'd0, a});
    y = longint'({32'd0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: edges remaining until ready, then hold.
  int          m_left = 0;
  logic        m_ready = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst || (annul && (m_ready || m_left > 0))) begin
      m_left  = 0;
      m_ready = 1'b0;
      m_res   = '0;
    end else if (m_ready) begin
      if (!start) begin
        m_ready = 1'b0;
        m_res   = '0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        m_res   = m_pend;
      end
    end else if (start && !annul) begin
      m_pend = ref_div(opa, opb, sg);
      m_left = (opb == 0) ? 1 : 33;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc ready", {63'd0, ready}, {63'd0, m_ready});
      chk("cyc result", result, m_res);
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [63:0] exp,
                     input int lat, input string nm);
    int n;
    opa = a;
    opb = b;
    sg = s;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 100);
    chk({nm, " latency"}, 64'(n), 64'(lat));
    chk({nm, " result"}, result, exp);
    start = 1'b0;
    opa = $urandom;
    opb = $urandom;
    @(posedge clk);
    #1;
    chk({nm, " drop ready"}, {63'd0, ready}, 64'd0);
    chk({nm, " drop result"}, result, 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    sg = 1'b0;
    opa = '0;
    opb = '0;
    start = 1'b0;
    annul = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("reset ready", {63'd0, ready}, 64'd0);
    chk("reset result", result, 64'd0);
    rst = 1'b0;

    chk("model 100/7", ref_div(32'd100, 32'd7, 1'b0),
        {32'd2, 32'd14});
    run(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34, "u100/7");

`ifdef DIV_SIGNED_EN
    chk("model -7/2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1),
        {32'hFFFFFFFF, 32'hFFFFFFFD});
    run(32'hFFFFFFF9, 32'd2, 1'b1,
        {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, "s-7/2");
    run(32'h80000000, 32'hFFFFFFFF, 1'b1,
        {32'd0, 32'h80000000}, 34, "sovf");
`else
    chk("model -7/2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1),
        {32'd1, 32'h7FFFFFFC});
    run(32'hFFFFFFF9, 32'd2, 1'b1,
        {32'd1, 32'h7FFFFFFC}, 34, "s-7/2");
    run(32'h80000000, 32'hFFFFFFFF, 1'b1,
        {32'h80000000, 32'd0}, 34, "sovf");
`endif

    run(32'd5, 32'd0, 1'b0, 64'd0, 2, "5/0");
    run(32'd7, 32'd100, 1'b0, {32'd7, 32'd0}, 34, "7/100");
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, {32'd0, 32'd1}, 34, "max/max");

    // annul during the 10th step cycle
    opa = 32'd1000;
    opb = 32'd3;
    sg = 1'b0;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul ready", {63'd0, ready}, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    run(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34, "9/3");

    // reset at counter 20
    opa = 32'd1234;
    opb = 32'd5;
    start = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst ready", {63'd0, ready}, 64'd0);
    chk("rst result", result, 64'd0);
    rst = 1'b0;
    run(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 34, "max/1");

    // start dropped mid-operation: END visited for one cycle
    opa = 32'd50;
    opb = 32'd5;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    n = 5;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 100);
    chk("early-drop latency", 64'(n), 64'd34);
    chk("early-drop result", result, {32'd0, 32'd10});
    @(posedge clk);
    #1;
    chk("early-drop ready", {63'd0, ready}, 64'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
